fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the single-issue CPU datapath. Owns the program counter, drives the address of the instruction memory (combinational-read, 32-bit words, word-addressed), and captures each returned word with its PC into a 2-entry prefetch buffer. Presents instructions to the decode stage through a valid/ready handshake. Supports same-cycle branch redirect with flush, and halt.

## Interface
- ADDR_W, 16, PC / instruction-memory address width (word address)
- INSTR_W, 32, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- imem_addr  out  ADDR_W  address to instruction memory (combinational)
- imem_data  in  INSTR_W  instruction memory read data, valid same cycle as imem_addr
- halt  in  1  suppress new fetches; buffer still drains
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  ADDR_W  target PC, sampled when redirect=1
- out_valid  out  1  buffer head valid
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  PC of head instruction

## Operation
- State: pc register, 2-entry FIFO of {pc, instr}, count 0..2.
- fetch_pc = redirect ? redirect_pc : pc; imem_addr = fetch_pc.
- pop = out_valid & out_ready.
- fetch = !halt & (redirect | count<2 | pop).
- On fetch: push {fetch_pc, imem_data}; pc <= fetch_pc + 1 (mod 2^ADDR_W, 0xFFFF wraps to 0x0000).
- No fetch: pc <= fetch_pc (redirect while halted still loads target).
- Redirect: FIFO contents discarded same edge (flush before push); count becomes 1 if fetched, else 0. A pop in the redirect cycle is still a completed transfer; the flushed entries are never presented again.
- Full with pop: push and pop same edge, count stays 2.
- Empty with push: head becomes visible next cycle (no bypass).
- out_instr/out_pc = head entry; when count=0 they hold 0.
- Order strictly preserved; no duplicate or skipped PCs except across redirect.

## Timing
- Reset (sync, priority over all inputs): pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0; imem_addr=RESET_PC during reset. No fetch occurs in reset cycles (memory is being initialised then).
- First cycle after reset released: fetch RESET_PC; out_valid=1 with out_pc=RESET_PC one cycle later.
- Fetch-to-output latency: 1 cycle. Redirect-to-target-at-output: 1 cycle, zero bubbles.
- Sustained throughput 1 instr/cycle with out_ready=1.
- Reset mid-operation: full buffer dropped, outputs return to reset values at next edge.
- Combinational paths: redirect/redirect_pc -> imem_addr; out_ready -> fetch decision. out_valid/out_instr/out_pc are registered-state only.

## Structure
- cpu_pkg: ADDR_W, INSTR_W, RESET_PC constants, fetch entry struct {pc, instr}.
- Sub-module fetch_fifo: 2-entry synchronous FIFO with push, pop, flush, count, head outputs; fetch_unit holds pc and control.

## Test plan
- Imem preloaded mem[0]=0x6F7A000A, mem[1]=0xD83BC000, mem[2]=0x6F380002; reset 2 cycles, out_ready=1 -> out_pc 0,1,2 on consecutive cycles with those words, out_valid=0 during reset and first post-reset cycle.
- out_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 2; release -> out_pc 0,1,2,3 in order, no repeats.
- Buffer full (pc 0,1), redirect=1 redirect_pc=0x0010 -> next cycle out_pc=0x0010, then 0x0011; pc 0,1 never presented again.
- redirect_pc=0xFFFF -> out_pc 0xFFFF then 0x0000.
- halt=1 with count=2, out_ready=1 -> drains 2 instrs then out_valid=0, imem_addr frozen; halt=0 -> resumes at next PC.
- reset asserted while full and mid-redirect -> next cycle out_valid=0, out_pc=0, pc=RESET_PC; restart fetches from 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, reset PC and the fetch buffer entry type
package cpu_pkg;
  localparam int ADDR_W = 16;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry prefetch buffer with same-edge flush, push and pop
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t e0, e1;
  logic [1:0] base;
  // base is how many old entries survive this edge, before the push lands
  assign base = flush ? 2'd0 : count - {1'b0, pop};
  assign head = count != 2'd0 ? e0 : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      count <= base + {1'b0, push};
      e0 <= base == 2'd0 ? (push ? din : e0) : (pop ? e1 : e0);
      e1 <= base == 2'd1 && push ? din : e1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, reads instruction memory and feeds decode via valid/ready
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               halt,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);
  logic [ADDR_W-1:0] pc, fetch_pc;
  logic [1:0] count;
  logic pop, fetch;
  fetch_entry_t head;
  assign fetch_pc = redirect ? redirect_pc : pc;
  assign imem_addr = reset ? RESET_PC : fetch_pc;
  assign out_valid = count != 2'd0;
  assign pop = out_valid & out_ready;
  // memory is still being initialised during reset, so nothing is fetched then
  assign fetch = !reset & !halt & (redirect | count != 2'd2 | pop);
  assign out_pc = head.pc;
  assign out_instr = head.instr;
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else pc <= fetch ? fetch_pc + 1'b1 : fetch_pc;
  end
  fetch_fifo u_fifo (
    .clk(clk),
    .reset(reset),
    .push(fetch),
    .pop(pop),
    .flush(redirect),
    .din('{pc: fetch_pc, instr: imem_data}),
    .count(count),
    .head(head)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch traffic against a queue-based model
module tb_fetch_unit;
  logic clk = 1'b0, reset = 1'b1, halt = 1'b0, redirect = 1'b0, out_ready = 1'b0;
  logic [15:0] redirect_pc = '0, imem_addr, out_pc;
  logic [31:0] imem_data, out_instr;
  logic out_valid;
  int checks = 0, failures = 0;
  typedef struct {logic [15:0] pc; logic [31:0] instr;} ent_t;
  ent_t q[$];
  logic [15:0] mpc = 16'h0000;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [15:0] a);
    return a == 16'd0 ? 32'h6F7A000A : a == 16'd1 ? 32'hD83BC000 :
           a == 16'd2 ? 32'h6F380002 : {a ^ 16'hA5C3, a * 16'd7 + 16'd3};
  endfunction
  assign imem_data = mem(imem_addr);
  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic h, input logic rd, input logic [15:0] rpc,
                      input logic rdy);
    logic [15:0] fpc;
    logic p, f;
    reset = r; halt = h; redirect = rd; redirect_pc = rpc; out_ready = rdy;
    #1;
    fpc = rd ? rpc : mpc;
    chk("imem_addr", {16'd0, imem_addr}, {16'd0, r ? 16'h0000 : fpc});
    if (r) begin
      q.delete();
      mpc = 16'h0000;
    end else begin
      p = q.size() > 0 && rdy;
      f = !h && (rd || q.size() < 2 || p);
      if (p) void'(q.pop_front());
      if (rd) q.delete();
      if (f) q.push_back('{pc: fpc, instr: mem(fpc)});
      mpc = f ? fpc + 16'd1 : fpc;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("out_pc", {16'd0, out_pc}, q.size() > 0 ? {16'd0, q[0].pc} : 32'd0);
    chk("out_instr", out_instr, q.size() > 0 ? q[0].instr : 32'd0);
  endtask
  task automatic go(input int n, input logic h, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, h, 1'b0, 16'h0, rdy);
  endtask
  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'h1234, 1'b1);
    chk("post_reset_valid", {31'd0, out_valid}, 32'd0);
    go(1, 1'b0, 1'b1);
    chk("first_pc", {16'd0, out_pc}, 32'd0);
    chk("first_instr", out_instr, 32'h6F7A000A);
    go(3, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    go(5, 1'b0, 1'b0);
    chk("saturated_addr", {16'd0, imem_addr}, 32'd2);
    go(6, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    go(3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0);
    chk("redirect_pc_out", {16'd0, out_pc}, 32'h10);
    go(3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    go(3, 1'b0, 1'b1);
    go(3, 1'b0, 1'b0);
    go(4, 1'b1, 1'b1);
    chk("halt_drained", {31'd0, out_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1);
    go(3, 1'b0, 1'b1);
    go(3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0077, 1'b1);
    chk("reset_mid_pc", {16'd0, out_pc}, 32'd0);
    go(3, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] t;
      t = $urandom_range(0, 3) == 0 ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           t, $urandom_range(0, 3) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
